// File: rtl/fib_rx_pkg.sv
// -----------------------------------------------------------------------------
// fib_rx_pkg
// Shared definitions for the FIB stream receiver:
//   - state_e        : receiver FSM state encoding (IDLE / RECV / DONE)
//   - MAX_WORDS_DEF  : default per-frame word capacity
//   - CRC_POLY       : CRC-8 generator polynomial (x^8 + x^2 + x + 1)
//   - crc8_update()  : one-byte CRC-8 step, MSB first, no reflection
// -----------------------------------------------------------------------------
package fib_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int         MAX_WORDS_DEF = 1024;
  localparam logic [7:0] CRC_POLY      = 8'h07;

  // Folds one data byte into the running CRC, processing the MSB first.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc_in,
                                             input logic [7:0] data);
    logic [7:0] c;
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/fib_rx_sync.sv
// -----------------------------------------------------------------------------
// fib_rx_sync
// Multi-flop synchronizer for signals arriving from the asynchronous FIB
// output stage, followed by one extra register used for edge detection.
//
// Parameters
//   WIDTH   : number of bits synchronized in parallel
//   STAGES  : synchronizer depth (2..4)
// Ports
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   d       in   asynchronous input bits
//   q       out  synchronized level (output of the last synchronizer stage)
//   rise    out  per-bit rising edge of q (one cycle)
//   fall    out  per-bit falling edge of q (one cycle)
// -----------------------------------------------------------------------------
module fib_rx_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [STAGES-1:0][WIDTH-1:0] chain_q;
  logic [WIDTH-1:0]             prev_q;

  // NOTE: the synchronizer chain is ordinary flop storage, not a RAM, so it
  // is cleared by reset; sequential state is always updated with '<=' so every
  // stage samples the value its predecessor held before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
      prev_q  <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
      prev_q  <= chain_q[STAGES-1];
    end
  end

  assign q    = chain_q[STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/fib_stream_rx.sv
// -----------------------------------------------------------------------------
// fib_stream_rx
// Receives framed byte streams from the FIB output stage. The word clock,
// frame envelope and data bus are synchronized into clk_in, words are
// captured on synchronized s_clk rising edges while a frame is open, and
// per-frame length, last word, CRC and sticky error flags are reported.
//
// Optional feature (macro FIB_RX_CRC_EN):
//   defined   : crc is CRC-8 (poly 0x07, init 0x00, MSB first, no xorout)
//   undefined : crc is tied to 8'h00 and no CRC logic exists
//
// Parameters
//   SYNC_STAGES : synchronizer depth for s_clk, s_syn, s_dout (2..4)
//   MAX_WORDS   : per-frame word capacity (at most 2047)
// Ports
//   clk_in      in   system clock
//   rst_n       in   asynchronous active-low reset
//   s_clk       in   stream word clock (asynchronous)
//   s_dout      in   stream data word [7:0]
//   s_syn       in   frame envelope, high during a frame
//   exp_length  in   expected words per frame [9:0], 0 means 1024
//   clr         in   one-cycle pulse clearing err_len / err_ovf
//   busy        out  high while a frame is being received
//   frame_done  out  one-cycle pulse when a frame's results are loaded
//   frame_len   out  words captured in the last completed frame [10:0]
//   last_word   out  most recently captured word [7:0]
//   err_len     out  sticky: a frame length differed from exp_length
//   err_ovf     out  sticky: words arrived beyond MAX_WORDS
//   crc         out  CRC-8 of the last completed frame [7:0]
// -----------------------------------------------------------------------------
module fib_stream_rx
  import fib_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_WORDS   = MAX_WORDS_DEF
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        s_clk,
  input  logic [7:0]  s_dout,
  input  logic        s_syn,
  input  logic [9:0]  exp_length,
  input  logic        clr,
  output logic        busy,
  output logic        frame_done,
  output logic [10:0] frame_len,
  output logic [7:0]  last_word,
  output logic        err_len,
  output logic        err_ovf,
  output logic [7:0]  crc
);

  localparam logic [10:0] MAX_CNT = 11'(MAX_WORDS);

  // ---------------------------------------------------------------------------
  // Synchronizers
  // ---------------------------------------------------------------------------
  logic       sclk_lvl, sclk_rise, sclk_fall;
  logic       syn_lvl, syn_rise, syn_fall;
  logic [7:0] dout_sync, dout_rise, dout_fall;

  fib_rx_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_clk (
    .clk  (clk_in),
    .rst_n(rst_n),
    .d    (s_clk),
    .q    (sclk_lvl),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  fib_rx_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_syn (
    .clk  (clk_in),
    .rst_n(rst_n),
    .d    (s_syn),
    .q    (syn_lvl),
    .rise (syn_rise),
    .fall (syn_fall)
  );

  // Data shares the control path's depth so a word is sampled on the same
  // cycle its s_clk edge is seen.
  fib_rx_sync #(.WIDTH(8), .STAGES(SYNC_STAGES)) u_sync_dat (
    .clk  (clk_in),
    .rst_n(rst_n),
    .d    (s_dout),
    .q    (dout_sync),
    .rise (dout_rise),
    .fall (dout_fall)
  );

  // Only edges of s_clk/s_syn and the level of the data bus are consumed.
  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, sclk_fall, syn_lvl, dout_rise, dout_fall};

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: next state is given a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (syn_rise) state_d = ST_RECV;
      ST_RECV: if (syn_fall) state_d = ST_DONE;
      ST_DONE: state_d = syn_rise ? ST_RECV : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Capture datapath
  // ---------------------------------------------------------------------------
  logic        in_recv, in_done, start;
  logic        cap, cap_ok, ovf_set, len_set;
  logic [10:0] cnt_q, exp_eff;

  assign in_recv = (state_q == ST_RECV);
  assign in_done = (state_q == ST_DONE);
  // A new frame can open from IDLE or directly out of DONE.
  assign start   = syn_rise && !in_recv;
  // Capture is evaluated on the current state, so a word whose edge coincides
  // with the s_syn fall is still taken before the frame closes.
  assign cap     = in_recv && sclk_rise;
  assign cap_ok  = cap && (cnt_q != MAX_CNT);
  assign ovf_set = cap && (cnt_q == MAX_CNT);
  assign exp_eff = (exp_length == '0) ? 11'd1024 : {1'b0, exp_length};
  assign len_set = in_done && (cnt_q != exp_eff);
  assign busy    = in_recv;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      last_word  <= '0;
      frame_done <= 1'b0;
      frame_len  <= '0;
      err_len    <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      frame_done <= in_done;
      if (start)       cnt_q <= '0;
      else if (cap_ok) cnt_q <= cnt_q + 11'd1;
      if (cap_ok)  last_word <= dout_sync;
      if (in_done) frame_len <= cnt_q;
      // Set has priority over a simultaneous clear.
      err_len <= len_set | (err_len & ~clr);
      err_ovf <= ovf_set | (err_ovf & ~clr);
    end
  end

  // ---------------------------------------------------------------------------
  // CRC
  // ---------------------------------------------------------------------------
`ifdef FIB_RX_CRC_EN
  logic [7:0] crc_run_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      crc_run_q <= '0;
      crc       <= '0;
    end else begin
      if (start)       crc_run_q <= '0;
      else if (cap_ok) crc_run_q <= crc8_update(crc_run_q, dout_sync);
      if (in_done) crc <= crc_run_q;
    end
  end
`else
  assign crc = 8'h00;
`endif

endmodule

// File: tb/tb_fib_stream_rx.sv
// -----------------------------------------------------------------------------
// tb_fib_stream_rx
// Self-checking bench for fib_stream_rx. Frames are described as queues of
// bytes; expected results come from a frame-level model (length clamp,
// sticky flags, bitwise CRC-8) evaluated after each frame.
// -----------------------------------------------------------------------------
module tb_fib_stream_rx;

  localparam int SYNC = 2;
  localparam int MAXW = 1024;
`ifdef FIB_RX_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b0;
  logic        s_clk  = 1'b0;
  logic        s_syn  = 1'b0;
  logic        clr    = 1'b0;
  logic [7:0]  s_dout = 8'h00;
  logic [9:0]  exp_length = 10'd0;
  logic        busy, frame_done, err_len, err_ovf;
  logic [10:0] frame_len;
  logic [7:0]  last_word, crc;

  fib_stream_rx #(.SYNC_STAGES(SYNC), .MAX_WORDS(MAXW)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .s_clk     (s_clk),
    .s_dout    (s_dout),
    .s_syn     (s_syn),
    .exp_length(exp_length),
    .clr       (clr),
    .busy      (busy),
    .frame_done(frame_done),
    .frame_len (frame_len),
    .last_word (last_word),
    .err_len   (err_len),
    .err_ovf   (err_ovf),
    .crc       (crc)
  );

  always #5 clk_in = ~clk_in;

  int n_tests  = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  // Reference model state
  logic [7:0]  tx_words[$];
  logic        m_err_len = 1'b0;
  logic        m_err_ovf = 1'b0;
  logic [10:0] m_len     = '0;
  logic [7:0]  m_last    = '0;
  logic [7:0]  m_crc     = '0;

  always @(posedge clk_in) begin
    #1;
    if (frame_done) done_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Bitwise CRC-8 over the first cnt words of tx_words.
  function automatic logic [7:0] ref_crc(input int cnt);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int k = 0; k < cnt; k++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ tx_words[k][b];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  task automatic drive_word(input logic [7:0] w, input int hi, input int lo);
    s_dout = w;
    cyc(2);
    s_clk = 1'b1;
    cyc(hi);
    s_clk = 1'b0;
    cyc(lo);
  endtask

  task automatic check_outputs(input string t);
    check($sformatf("%s.frame_len", t), 32'(frame_len), 32'(m_len));
    check($sformatf("%s.last_word", t), 32'(last_word), 32'(m_last));
    check($sformatf("%s.err_len", t),   32'(err_len),   32'(m_err_len));
    check($sformatf("%s.err_ovf", t),   32'(err_ovf),   32'(m_err_ovf));
    check($sformatf("%s.crc", t),       32'(crc),       CRC_EN ? 32'(m_crc) : 32'h0);
  endtask

  // Sends tx_words as one frame and checks the results against the model.
  task automatic run_frame(input string t, input int exp_l, input bit coincide,
                           input int hi, input int lo);
    int n, cap, exp_eff, d0, lat;
    n  = tx_words.size();
    d0 = done_cnt;
    exp_length = 10'(exp_l);
    s_syn = 1'b1;
    cyc(5);
    for (int i = 0; i < n - 1; i++) drive_word(tx_words[i], hi, lo);
    check($sformatf("%s.busy_in_frame", t), 32'(busy), 32'h1);
    if (coincide) begin
      s_dout = tx_words[n-1];
      cyc(2);
      s_clk = 1'b1;
      s_syn = 1'b0;
    end else begin
      drive_word(tx_words[n-1], hi, lo);
      cyc(2);
      s_syn = 1'b0;
    end
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk_in);
      #1;
      if (frame_done) begin
        lat = k;
        break;
      end
    end
    @(negedge clk_in);
    s_clk = 1'b0;
    cyc(lo + 4);

    cap     = (n > MAXW) ? MAXW : n;
    exp_eff = (exp_l == 0) ? 1024 : exp_l;
    if (cap != exp_eff) m_err_len = 1'b1;
    if (n > MAXW)       m_err_ovf = 1'b1;
    m_len  = 11'(cap);
    m_last = tx_words[cap-1];
    m_crc  = ref_crc(cap);

    check($sformatf("%s.latency", t),     32'(lat),           32'(SYNC + 2));
    check($sformatf("%s.done_pulses", t), 32'(done_cnt - d0), 32'h1);
    check($sformatf("%s.busy_after", t),  32'(busy),          32'h0);
    check_outputs(t);
  endtask

  task automatic pulse_clr(input string t);
    @(negedge clk_in);
    clr = 1'b1;
    @(negedge clk_in);
    clr = 1'b0;
    m_err_len = 1'b0;
    m_err_ovf = 1'b0;
    cyc(1);
    check($sformatf("%s.err_len", t), 32'(err_len), 32'h0);
    check($sformatf("%s.err_ovf", t), 32'(err_ovf), 32'h0);
  endtask

  task automatic fill_random(input int n);
    tx_words.delete();
    for (int i = 0; i < n; i++) tx_words.push_back(8'($urandom));
  endtask

  initial begin
    int d0, n, e;

    // Reset state
    cyc(3);
    check("rst.busy", 32'(busy), 32'h0);
    check("rst.frame_done", 32'(frame_done), 32'h0);
    check_outputs("rst");
    rst_n = 1'b1;
    cyc(4);

    // Basic 3-word frame
    tx_words = '{8'h01, 8'h02, 8'h03};
    run_frame("f3", 3, 1'b0, 4, 4);

    // Single word 0x01: known CRC vector
    tx_words = '{8'h01};
    run_frame("f1", 1, 1'b0, 4, 4);
    check("f1.crc_vector", 32'(crc), CRC_EN ? 32'h07 : 32'h00);

    // Overflow: 1025 words, exp_length 0 (=1024)
    fill_random(1025);
    run_frame("ovf", 0, 1'b0, 4, 4);
    pulse_clr("ovf_clr");

    // Length error and its stickiness
    fill_random(5);
    run_frame("len5", 4, 1'b0, 4, 5);
    fill_random(4);
    run_frame("len4_ok", 4, 1'b0, 5, 4);
    pulse_clr("len_clr");

    // Last word coincident with the s_syn fall, then stray s_clk edges
    fill_random(3);
    run_frame("coinc", 3, 1'b1, 5, 5);
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) drive_word(8'($urandom), 4, 4);
    cyc(5);
    check("idle_clk.done_pulses", 32'(done_cnt - d0), 32'h0);
    check("idle_clk.busy", 32'(busy), 32'h0);
    check_outputs("idle_clk");

    // Reset in the middle of a frame
    fill_random(2);
    exp_length = 10'd4;
    s_syn = 1'b1;
    cyc(5);
    for (int i = 0; i < 2; i++) drive_word(tx_words[i], 4, 4);
    check("abort.busy_before", 32'(busy), 32'h1);
    d0 = done_cnt;
    rst_n = 1'b0;
    s_syn = 1'b0;
    s_clk = 1'b0;
    m_err_len = 1'b0;
    m_err_ovf = 1'b0;
    m_len  = '0;
    m_last = '0;
    m_crc  = '0;
    cyc(2);
    check("abort.busy_rst", 32'(busy), 32'h0);
    check("abort.frame_done_rst", 32'(frame_done), 32'h0);
    check_outputs("abort_rst");
    rst_n = 1'b1;
    cyc(10);
    check("abort.done_pulses", 32'(done_cnt - d0), 32'h0);
    check("abort.busy_after", 32'(busy), 32'h0);
    fill_random(4);
    run_frame("after_abort", 4, 1'b0, 4, 4);

    // Randomized frames
    for (int f = 0; f < 10; f++) begin
      n = int'($urandom_range(1, 20));
      e = ($urandom_range(0, 1) == 0) ? n : int'($urandom_range(1, 20));
      fill_random(n);
      run_frame($sformatf("rnd%0d", f), e, 1'($urandom_range(0, 1)),
                int'($urandom_range(4, 6)), int'($urandom_range(4, 6)));
      if ($urandom_range(0, 2) == 0) pulse_clr($sformatf("rnd%0d_clr", f));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
